cskipa_6bit_stim_checker: RTL

//  Initiator/checker on the far end of the CSkipA_6bit operand/result interface.
//  - Drives i_add_term1/i_add_term2 into a combinational carry-skip adder instance.
//  - Waits a settle window, then samples sum/cout and compares them with a golden a+b.
//  - Used for post-synthesis netlist sign-off of the adder family.
//  - Reports pass/fail, error count and the first failing vector.

---
 rtl/cskipa_6bit_stim_checker.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/cskipa_6bit_stim_checker.sv
// Stimulus generator and result checker for a combinational CSkipA_6bit adder.
// Optional CSKIPA_STIM_STOP_ON_FAIL_EN: end the run at the first mismatching vector.
module cskipa_6bit_stim_checker #(
    parameter int unsigned             WIDTH         = 6,
    parameter int unsigned             SETTLE_CYCLES = 2,
    parameter int unsigned             RAND_COUNT    = 256,
    parameter logic [2*WIDTH-1:0]      LFSR_SEED     = 12'hACE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 mode,
    output logic [WIDTH-1:0]     o_add_term1,
    output logic [WIDTH-1:0]     o_add_term2,
    input  logic [WIDTH-1:0]     i_sum,
    input  logic                 i_cout,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [15:0]          err_count,
    output logic [2*WIDTH-1:0]   fail_vec
);

    localparam int unsigned LW = 2 * WIDTH;
    localparam int unsigned RW = WIDTH + 1;
    localparam int unsigned CW = (LW > 16) ? LW : 16;
    localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [CW-1:0] EXH_LAST = CW'((64'd1 << LW) - 64'd1);
    localparam logic [CW-1:0] RND_LAST = CW'(RAND_COUNT - 1);

    // Feedback taps: maximal-length polynomials for common widths, x^n+x+1 otherwise.
    function automatic logic [LW-1:0] tap_mask();
        logic [LW-1:0] m;
        m = '0;
        case (LW)
            8:       m = LW'(8'hB8);
            10:      m = LW'(10'h240);
            12:      m = LW'(12'h829);
            14:      m = LW'(14'h2015);
            16:      m = LW'(16'hD008);
            default: begin
                m[LW-1] = 1'b1;
                m[0]    = 1'b1;
            end
        endcase
        return m;
    endfunction

    localparam logic [LW-1:0] TAPS = tap_mask();

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        FIN    = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic              mode_q, mode_d;
    logic [15:0]       err_q, err_d;
    logic [LW-1:0]     fv_q, fv_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [LW-1:0]     lfsr_q, lfsr_d;
    logic [SW-1:0]     settle_q, settle_d;

    logic [RW-1:0]     golden_c;
    logic              mismatch_c, last_c, fin_c;
    logic [15:0]       err_inc_c;
    logic [LW-1:0]     lfsr_next_c;

    assign golden_c    = RW'(a_q) + RW'(b_q);
    assign mismatch_c  = ({i_cout, i_sum} != golden_c);
    assign last_c      = mode_q ? (cnt_q == RND_LAST) : (cnt_q == EXH_LAST);
    assign err_inc_c   = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
    assign lfsr_next_c = {lfsr_q[LW-2:0], ^(lfsr_q & TAPS)};
`ifdef CSKIPA_STIM_STOP_ON_FAIL_EN
    assign fin_c       = last_c || mismatch_c;
`else
    assign fin_c       = last_c;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            mode_q   <= 1'b0;
            err_q    <= '0;
            fv_q     <= '0;
            cnt_q    <= '0;
            lfsr_q   <= LFSR_SEED;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            mode_q   <= mode_d;
            err_q    <= err_d;
            fv_q     <= fv_d;
            cnt_q    <= cnt_d;
            lfsr_q   <= lfsr_d;
            settle_q <= settle_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        pass_d   = pass_q;
        mode_d   = mode_q;
        err_d    = err_q;
        fv_d     = fv_q;
        cnt_d    = cnt_q;
        lfsr_d   = lfsr_q;
        settle_d = settle_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DRIVE;
                    busy_d  = 1'b1;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    fv_d    = '0;
                    mode_d  = mode;
                    cnt_d   = '0;
                    lfsr_d  = LFSR_SEED;
                end
            end
            DRIVE: begin
                {a_d, b_d} = mode_q ? lfsr_q : cnt_q[LW-1:0];
                settle_d   = '0;
                state_d    = SETTLE;
            end
            SETTLE: begin
                if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
                    state_d = CHECK;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            CHECK: begin
                lfsr_d = lfsr_next_c;
                if (mismatch_c) begin
                    err_d = err_inc_c;
                    if (err_q == 16'd0) begin
                        fv_d = {a_q, b_q};
                    end
                end
                // Counter never advances past the final vector, so it cannot wrap.
                if (fin_c) begin
                    state_d = FIN;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_q == 16'd0) && !mismatch_c;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = DRIVE;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign o_add_term1 = a_q;
    assign o_add_term2 = b_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign err_count   = err_q;
    assign fail_vec    = fv_q;

endmodule
